// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the 8N1 UART transceiver.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 3333;

    localparam int       DATA_BITS = 8;
    localparam logic     START_LVL = 1'b0;
    localparam logic     STOP_LVL  = 1'b1;

    typedef logic [1:0] uart_state_t;
    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_if.sv
// Byte-side handshake between control logic (master) and the UART (slave).
// frame_err is present only when UART_FRAME_ERR_EN is defined.
interface uart_if;
    import uart_pkg::*;

    logic                 en;
    logic [DATA_BITS-1:0] data_in;
    logic                 rdy;
    logic                 valid;
    logic [DATA_BITS-1:0] data_out;
`ifdef UART_FRAME_ERR_EN
    logic                 frame_err;

    modport master (output en, data_in, input rdy, valid, data_out, frame_err);
    modport slave  (input en, data_in, output rdy, valid, data_out, frame_err);
`else
    modport master (output en, data_in, input rdy, valid, data_out);
    modport slave  (input en, data_in, output rdy, valid, data_out);
`endif

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc is high while the count sits at zero (no wrap).
module uart_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with independent TX and RX state machines.
// Optional frame_err output enabled by defining UART_FRAME_ERR_EN.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    din,
    output logic    dout,
    uart_if.slave   bus
);

    localparam int               CW        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]    FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    // ---------------- transmit path ----------------
    uart_state_t          tx_state_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic [2:0]           tx_idx_reg;
    logic                 tx_dout_reg;
    logic                 tx_rdy_reg;
    logic                 tx_load;
    logic                 tx_tc;

    // Every bit period is (re)started by a load; leaving STOP needs no reload.
    assign tx_load = (tx_state_reg == ST_IDLE) ? bus.en
                                               : (tx_tc && tx_state_reg != ST_STOP);

    uart_bit_timer #(.WIDTH(CW)) u_tx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .load_val (FULL_LOAD),
        .tc       (tx_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_reg <= ST_IDLE;
            tx_shift_reg <= '0;
            tx_idx_reg   <= '0;
            tx_dout_reg  <= STOP_LVL;
            tx_rdy_reg   <= 1'b1;
        end else begin
            case (tx_state_reg)
                ST_IDLE: if (bus.en) begin
                    tx_shift_reg <= bus.data_in;
                    tx_state_reg <= ST_START;
                    tx_dout_reg  <= START_LVL;
                    tx_rdy_reg   <= 1'b0;
                end
                ST_START: if (tx_tc) begin
                    tx_state_reg <= ST_DATA;
                    tx_idx_reg   <= '0;
                    tx_dout_reg  <= tx_shift_reg[0];
                    tx_shift_reg <= tx_shift_reg >> 1;
                end
                ST_DATA: if (tx_tc) begin
                    if (tx_idx_reg == LAST_BIT) begin
                        tx_state_reg <= ST_STOP;
                        tx_dout_reg  <= STOP_LVL;
                    end else begin
                        tx_idx_reg   <= tx_idx_reg + 1'b1;
                        tx_dout_reg  <= tx_shift_reg[0];
                        tx_shift_reg <= tx_shift_reg >> 1;
                    end
                end
                ST_STOP: if (tx_tc) begin
                    tx_state_reg <= ST_IDLE;
                    tx_rdy_reg   <= 1'b1;
                end
                default: tx_state_reg <= ST_IDLE;
            endcase
        end
    end

    assign dout    = tx_dout_reg;
    assign bus.rdy = tx_rdy_reg;

    // ---------------- receive path ----------------
    uart_state_t          rx_state_reg;
    logic [1:0]           rx_sync_reg;
    logic                 rx_prev_reg;
    logic [DATA_BITS-1:0] rx_shift_reg;
    logic [2:0]           rx_idx_reg;
    logic                 rx_hold_reg;
    logic                 rx_valid_reg;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_line;
    logic                 rx_fall;
    logic                 rx_load;
    logic [CW-1:0]        rx_load_val;
    logic                 rx_tc;

    assign rx_line     = rx_sync_reg[1];
    assign rx_fall     = rx_prev_reg && !rx_line;
    assign rx_load     = (rx_state_reg == ST_IDLE) ? rx_fall
                       : (rx_tc && (rx_state_reg == ST_START || rx_state_reg == ST_DATA));
    assign rx_load_val = (rx_state_reg == ST_IDLE) ? HALF_LOAD : FULL_LOAD;

    uart_bit_timer #(.WIDTH(CW)) u_rx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tc       (rx_tc)
    );

`ifdef UART_FRAME_ERR_EN
    logic rx_ferr_reg;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_ferr_reg <= 1'b0;
        end else begin
            rx_ferr_reg <= (rx_state_reg == ST_STOP) && !rx_hold_reg && rx_tc
                           && (rx_line != STOP_LVL);
        end
    end
    assign bus.frame_err = rx_ferr_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync_reg  <= 2'b11;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= ST_IDLE;
            rx_shift_reg <= '0;
            rx_idx_reg   <= '0;
            rx_hold_reg  <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= '0;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[0], din};
            rx_prev_reg  <= rx_line;
            rx_valid_reg <= 1'b0;
            case (rx_state_reg)
                ST_IDLE: if (rx_fall) rx_state_reg <= ST_START;
                ST_START: if (rx_tc) begin
                    rx_state_reg <= (rx_line == START_LVL) ? ST_DATA : ST_IDLE;
                    rx_idx_reg   <= '0;
                end
                ST_DATA: if (rx_tc) begin
                    rx_shift_reg <= {rx_line, rx_shift_reg[DATA_BITS-1:1]};
                    rx_idx_reg   <= rx_idx_reg + 1'b1;
                    if (rx_idx_reg == LAST_BIT) rx_state_reg <= ST_STOP;
                end
                ST_STOP: begin
                    // After a bad stop bit, stay here until the line idles high again.
                    if (rx_hold_reg) begin
                        if (rx_line == STOP_LVL) begin
                            rx_hold_reg  <= 1'b0;
                            rx_state_reg <= ST_IDLE;
                        end
                    end else if (rx_tc) begin
                        if (rx_line == STOP_LVL) begin
                            rx_data_reg  <= rx_shift_reg;
                            rx_valid_reg <= 1'b1;
                            rx_state_reg <= ST_IDLE;
                        end else begin
                            rx_hold_reg  <= 1'b1;
                        end
                    end
                end
                default: rx_state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.valid    = rx_valid_reg;
    assign bus.data_out = rx_data_reg;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver at CLKS_PER_BIT=16.
module tb_uart_transceiver;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din;
    logic dout;
    logic din_drv = 1'b1;
    logic loopback = 1'b0;

    uart_if bus ();

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    assign din = loopback ? dout : din_drv;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    logic [7:0] rx_log [0:15];

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (valid_cnt < 16) rx_log[valid_cnt] = bus.data_out;
            valid_cnt = valid_cnt + 1;
        end
`ifdef UART_FRAME_ERR_EN
        if (bus.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      din_drv = 1'b0;
            else if (i == 9) din_drv = stop_bit;
            else             din_drv = b[i-1];
            repeat (CPB) @(negedge clk);
        end
        din_drv = 1'b1;
    endtask

    // Counts negedges with rdy low; optionally pulses en with junk while busy.
    task automatic wait_rdy(input string tag, input int junk_at, output int cycles);
        cycles = 0;
        while (bus.rdy !== 1'b1 && cycles < 400) begin
            if (cycles == junk_at) begin
                bus.en = 1'b1;
                bus.data_in = 8'hAA;
            end else begin
                bus.en = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        bus.en = 1'b0;
        if (cycles >= 400) check({tag, "_timeout"}, 32'(bus.rdy), 32'd1);
    endtask

    initial begin
        int cnt;
        int base;
        logic [9:0] frame;
        logic [9:0] exp_tx;

        bus.en = 1'b0;
        bus.data_in = 8'h00;

        // 1: reset
        repeat (3) @(negedge clk);
        check("reset_rdy", 32'(bus.rdy), 32'd1);
        check("reset_dout", 32'(dout), 32'd1);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_data_out", 32'(bus.data_out), 32'h00);
`ifdef UART_FRAME_ERR_EN
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
`endif
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 2: TX 8'hA5, busy en ignored, data_in changed after capture
        exp_tx = 10'b11_0100_1010;
        bus.data_in = 8'hA5;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        bus.data_in = 8'h00;
        cnt = 0;
        frame = '0;
        for (int k = 0; k < 400; k++) begin
            if (k == 50) begin
                bus.en = 1'b1;
                bus.data_in = 8'hC3;
            end else begin
                bus.en = 1'b0;
            end
            if (bus.rdy === 1'b1) break;
            cnt++;
            if (k % CPB == CPB / 2 && k / CPB < 10) frame[k / CPB] = dout;
            @(negedge clk);
        end
        bus.en = 1'b0;
        check("tx_rdy_low_cycles", 32'(cnt), 32'd160);
        for (int b = 0; b < 10; b++) begin
            check($sformatf("tx_a5_bit%0d", b), 32'(frame[b]), 32'(exp_tx[b]));
        end
        check("tx_idle_dout", 32'(dout), 32'd1);

        // 3: RX 8'h3C
        base = valid_cnt;
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        check("rx_3c_valid_count", 32'(valid_cnt - base), 32'd1);
        check("rx_3c_data", 32'(bus.data_out), 32'h3C);
        repeat (30) @(negedge clk);
        check("rx_3c_held", 32'(bus.data_out), 32'h3C);
        check("rx_3c_valid_low", 32'(bus.valid), 32'd0);

        // 4: glitch then 8'h55
        base = valid_cnt;
        din_drv = 1'b0;
        repeat (4) @(negedge clk);
        din_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_valid", 32'(valid_cnt - base), 32'd0);
        send_frame(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        check("rx_55_valid_count", 32'(valid_cnt - base), 32'd1);
        check("rx_55_data", 32'(bus.data_out), 32'h55);

        // 5: bad stop bit, then recovery with 8'h81
        base = valid_cnt;
        send_frame(8'hFF, 1'b0);
        repeat (20) @(negedge clk);
        check("badstop_no_valid", 32'(valid_cnt - base), 32'd0);
        check("badstop_data_kept", 32'(bus.data_out), 32'h55);
`ifdef UART_FRAME_ERR_EN
        check("badstop_frame_err", 32'(ferr_cnt), 32'd1);
`endif
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        check("rearm_valid_count", 32'(valid_cnt - base), 32'd1);
        check("rearm_data", 32'(bus.data_out), 32'h81);

        // Reset in the middle of a TX frame
        base = valid_cnt;
        bus.data_in = 8'h0F;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (40) @(negedge clk);
        check("midframe_busy", 32'(bus.rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midframe_rst_dout", 32'(dout), 32'd1);
        check("midframe_rst_rdy", 32'(bus.rdy), 32'd1);
        repeat (200) @(negedge clk);
        check("midframe_rst_no_valid", 32'(valid_cnt - base), 32'd0);

        // 6: loopback, 8'h00 then 8'hFF back-to-back
        loopback = 1'b1;
        repeat (5) @(negedge clk);
        base = valid_cnt;
        bus.data_in = 8'h00;
        bus.en = 1'b1;
        @(negedge clk);
        wait_rdy("loop_first", 70, cnt);
        check("loop_first_len", 32'(cnt), 32'd160);
        bus.data_in = 8'hFF;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        check("loop_back_to_back", 32'(bus.rdy), 32'd0);
        wait_rdy("loop_second", 90, cnt);
        check("loop_second_len", 32'(cnt), 32'd160);
        repeat (40) @(negedge clk);
        check("loop_valid_count", 32'(valid_cnt - base), 32'd2);
        check("loop_byte0", 32'(rx_log[base]), 32'h00);
        check("loop_byte1", 32'(rx_log[base + 1]), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
